// File: rtl/tcp_vlg_ack_rx.sv
// Remote-ack processor: tracks cumulative ack/window, counts duplicate acks for fast retransmit
// and runs the retransmission timer. Define TCP_VLG_RTO_BACKOFF_EN for exponential RTO backoff.
module tcp_vlg_ack_rx #(
   parameter int RTO_TICKS = 2500,
   parameter int DUP_ACKS  = 3,
   parameter int VERBOSE   = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          connected_i,
   input  logic                          init_i,
   input  logic [31:0]                   init_ack_i,
   input  logic [15:0]                   init_wnd_i,
   input  logic [31:0]                   loc_seq_i,
   input  logic                          rx_val_i,
   input  logic                          rx_ack_flag_i,
   input  logic [31:0]                   rx_ack_i,
   input  logic [15:0]                   rx_pld_len_i,
   input  logic [15:0]                   rx_wnd_i,
   output logic [31:0]                   rem_ack_o,
   output logic [15:0]                   rem_wnd_o,
   output logic                          acked_upd_o,
   output logic [$clog2(DUP_ACKS+1)-1:0] dup_cnt_o,
   output logic                          fast_rtx_o,
   output logic                          rto_o,
   input  logic                          rtx_done_i
);
   localparam int DW = $clog2(DUP_ACKS + 1);
`ifdef TCP_VLG_RTO_BACKOFF_EN
   localparam int TW = $clog2(8 * RTO_TICKS + 1);
`else
   localparam int TW = $clog2(RTO_TICKS + 1);
`endif
   localparam logic [DW-1:0] DUP_MAX  = DW'(DUP_ACKS);
   localparam logic [TW-1:0] RTO_BASE = TW'(RTO_TICKS);

   logic [31:0]   rem_ack_q, rem_ack_d;
   logic [15:0]   rem_wnd_q, rem_wnd_d;
   logic          acked_upd_q, acked_upd_d;
   logic [DW-1:0] dup_cnt_q, dup_cnt_d;
   logic          fast_rtx_q, fast_rtx_d;
   logic          rto_q, rto_d;
   logic [TW-1:0] timer_q, timer_d, limit_s;
   logic [31:0]   d_s, o_s;
   logic          eval_s, new_ack_s, dup_s, wnd_upd_s;
`ifdef TCP_VLG_RTO_BACKOFF_EN
   logic [1:0]    bo_q, bo_d;
`endif

   // VERBOSE only controls simulation displays; nothing in the datapath depends on it.
   if (VERBOSE != 0) begin : g_verbose
   end

   // Sequence-space distances are modulo 2^32, so plain wrapping subtraction is exact.
   assign d_s       = rx_ack_i - rem_ack_q;
   assign o_s       = loc_seq_i - rem_ack_q;
   assign eval_s    = rx_val_i && rx_ack_flag_i && connected_i;
   assign new_ack_s = eval_s && (d_s != 32'd0) && (d_s <= o_s);
   assign dup_s     = eval_s && (d_s == 32'd0) && (rx_pld_len_i == 16'd0) &&
                      (o_s != 32'd0) && (rx_wnd_i == rem_wnd_q);
   assign wnd_upd_s = eval_s && (d_s == 32'd0) && !dup_s;
`ifdef TCP_VLG_RTO_BACKOFF_EN
   assign limit_s   = RTO_BASE << bo_q;
`else
   assign limit_s   = RTO_BASE;
`endif

   // Next-state: init > disconnect > new ack > rtx_done > dup/timer events.
   always_comb begin
      rem_ack_d   = rem_ack_q;
      rem_wnd_d   = rem_wnd_q;
      acked_upd_d = 1'b0;
      dup_cnt_d   = dup_cnt_q;
      fast_rtx_d  = fast_rtx_q;
      rto_d       = rto_q;
      timer_d     = timer_q;
`ifdef TCP_VLG_RTO_BACKOFF_EN
      bo_d        = bo_q;
`endif
      if (init_i) begin
         rem_ack_d  = init_ack_i;
         rem_wnd_d  = init_wnd_i;
         dup_cnt_d  = '0;
         fast_rtx_d = 1'b0;
         rto_d      = 1'b0;
         timer_d    = '0;
`ifdef TCP_VLG_RTO_BACKOFF_EN
         bo_d       = 2'd0;
`endif
      end else if (!connected_i) begin
         dup_cnt_d  = '0;
         fast_rtx_d = 1'b0;
         rto_d      = 1'b0;
         timer_d    = '0;
      end else if (new_ack_s) begin
         rem_ack_d   = rx_ack_i;
         rem_wnd_d   = rx_wnd_i;
         acked_upd_d = 1'b1;
         dup_cnt_d   = '0;
         fast_rtx_d  = 1'b0;
         rto_d       = 1'b0;
         timer_d     = '0;
`ifdef TCP_VLG_RTO_BACKOFF_EN
         bo_d        = 2'd0;
`endif
      end else begin
         if (wnd_upd_s) begin
            rem_wnd_d = rx_wnd_i;
         end else begin
            rem_wnd_d = rem_wnd_q;
         end
         if (rtx_done_i) begin
            fast_rtx_d = 1'b0;
            rto_d      = 1'b0;
            timer_d    = '0;
         end else begin
            // Saturated counter means this episode already requested its fast retransmit.
            if (dup_s && (dup_cnt_q != DUP_MAX)) begin
               dup_cnt_d  = dup_cnt_q + DW'(1);
               fast_rtx_d = (dup_cnt_q == (DUP_MAX - DW'(1))) ? 1'b1 : fast_rtx_q;
            end else begin
               dup_cnt_d  = dup_cnt_q;
            end
            if ((o_s != 32'd0) && !rto_q) begin
               if (timer_q == (limit_s - TW'(1))) begin
                  rto_d   = 1'b1;
                  timer_d = '0;
`ifdef TCP_VLG_RTO_BACKOFF_EN
                  bo_d    = (bo_q == 2'd3) ? 2'd3 : (bo_q + 2'd1);
`endif
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end else begin
               timer_d = '0;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rem_ack_q   <= 32'd0;
         rem_wnd_q   <= 16'd0;
         acked_upd_q <= 1'b0;
         dup_cnt_q   <= '0;
         fast_rtx_q  <= 1'b0;
         rto_q       <= 1'b0;
         timer_q     <= '0;
`ifdef TCP_VLG_RTO_BACKOFF_EN
         bo_q        <= 2'd0;
`endif
      end else begin
         rem_ack_q   <= rem_ack_d;
         rem_wnd_q   <= rem_wnd_d;
         acked_upd_q <= acked_upd_d;
         dup_cnt_q   <= dup_cnt_d;
         fast_rtx_q  <= fast_rtx_d;
         rto_q       <= rto_d;
         timer_q     <= timer_d;
`ifdef TCP_VLG_RTO_BACKOFF_EN
         bo_q        <= bo_d;
`endif
      end
   end

   assign rem_ack_o   = rem_ack_q;
   assign rem_wnd_o   = rem_wnd_q;
   assign acked_upd_o = acked_upd_q;
   assign dup_cnt_o   = dup_cnt_q;
   assign fast_rtx_o  = fast_rtx_q;
   assign rto_o       = rto_q;

endmodule
